// File: rtl/seg_pkg.sv
// Shared constants for the stopwatch seven-segment scan stage.
// Segment codes are active-high with bit 0 = a .. bit 6 = g, bit 7 = dp.
package seg_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [7:0] SEG_0    = 8'h3F;
    localparam logic [7:0] SEG_1    = 8'h06;
    localparam logic [7:0] SEG_2    = 8'h5B;
    localparam logic [7:0] SEG_3    = 8'h4F;
    localparam logic [7:0] SEG_4    = 8'h66;
    localparam logic [7:0] SEG_5    = 8'h6D;
    localparam logic [7:0] SEG_6    = 8'h7D;
    localparam logic [7:0] SEG_7    = 8'h07;
    localparam logic [7:0] SEG_8    = 8'h7F;
    localparam logic [7:0] SEG_9    = 8'h6F;
    localparam logic [7:0] SEG_DASH = 8'h40;
    localparam logic [7:0] SEG_DP   = 8'h80;
    localparam logic [7:0] SEG_OFF  = 8'h00;

    localparam logic [2:0] IDX_MS_UNITS  = 3'd0;
    localparam logic [2:0] IDX_MS_TENS   = 3'd1;
    localparam logic [2:0] IDX_SEC_UNITS = 3'd2;
    localparam logic [2:0] IDX_SEC_TENS  = 3'd3;
    localparam logic [2:0] IDX_MIN_UNITS = 3'd4;
    localparam logic [2:0] IDX_MIN_TENS  = 3'd5;

    // Packed so that nibble k of the flat vector is display digit k.
    typedef struct packed {
        logic [7:0] minute;
        logic [7:0] second;
        logic [7:0] ms;
    } snap_t;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-high seven-segment code.
// Non-decimal nibbles show a dash so corrupt inputs are visible.
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        case (nibble)
            4'd0:    seg = SEG_0[6:0];
            4'd1:    seg = SEG_1[6:0];
            4'd2:    seg = SEG_2[6:0];
            4'd3:    seg = SEG_3[6:0];
            4'd4:    seg = SEG_4[6:0];
            4'd5:    seg = SEG_5[6:0];
            4'd6:    seg = SEG_6[6:0];
            4'd7:    seg = SEG_7[6:0];
            4'd8:    seg = SEG_8[6:0];
            4'd9:    seg = SEG_9[6:0];
            default: seg = SEG_DASH[6:0];
        endcase
    end

endmodule

// File: rtl/stopwatch_seg_scan.sv
// Six-digit multiplexed display driver for the stopwatch (MM.SS.cc).
// Scans one digit per slot with a blanking gap and a per-frame input snapshot.
module stopwatch_seg_scan
    import seg_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit SEL_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] millsecond_10,
    input  logic [7:0] second,
    input  logic [7:0] minute,
    output logic [5:0] sel,
    output logic [7:0] seg
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] BLANK_LIM = DIV_W'(BLANK_CYCLES);
    localparam logic [5:0] SEL_IDLE = SEL_ACTIVE_LOW ? 6'h3F : 6'h00;
    localparam logic [7:0] SEG_IDLE = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
    logic [2:0]       idx_reg, idx_next;
    snap_t            snap_reg, snap_next;
    logic [5:0]       sel_reg, sel_next;
    logic [7:0]       seg_reg, seg_next;

    logic [23:0] snap_bits;
    logic [6:0]  dec [NUM_DIGITS];
    logic [6:0]  dec_cur;
    logic        last_slot;
    logic        frame_end;
    logic [5:0]  sel_act;
    logic [7:0]  seg_act;

    assign snap_bits = snap_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_dec
            bcd_to_seg u_dec (
                .nibble (snap_bits[gi*4 +: 4]),
                .seg    (dec[gi])
            );
        end
    endgenerate

    assign dec_cur   = (idx_reg <= IDX_MIN_TENS) ? dec[idx_reg] : 7'd0;
    assign last_slot = (div_cnt_reg == DIV_MAX);
    assign frame_end = last_slot && (idx_reg == IDX_MIN_TENS);

    always_comb begin
        div_cnt_next = div_cnt_reg;
        idx_next     = idx_reg;
        snap_next    = snap_reg;
        if (!en) begin
            div_cnt_next = '0;
            idx_next     = '0;
            snap_next    = '{minute: minute, second: second, ms: millsecond_10};
        end else begin
            if (last_slot) begin
                div_cnt_next = '0;
                idx_next     = (idx_reg == IDX_MIN_TENS) ? 3'd0 : idx_reg + 3'd1;
            end else begin
                div_cnt_next = div_cnt_reg + 1'b1;
            end
            // Reload at the very end of the frame so the next one starts fresh.
            if (frame_end) begin
                snap_next = '{minute: minute, second: second, ms: millsecond_10};
            end
        end
    end

    always_comb begin
        sel_act = 6'd0;
        seg_act = SEG_OFF;
        if (en && (div_cnt_reg >= BLANK_LIM)) begin
            sel_act = 6'd1 << idx_reg;
            seg_act = {1'b0, dec_cur};
            if (idx_reg == IDX_SEC_UNITS || idx_reg == IDX_MIN_UNITS) begin
                seg_act = seg_act | SEG_DP;
            end
            // Leading zero of minutes stays dark while its select still strobes.
            if (idx_reg == IDX_MIN_TENS && snap_reg.minute[7:4] == 4'd0) begin
                seg_act = SEG_OFF;
            end
        end
        sel_next = SEL_ACTIVE_LOW ? ~sel_act : sel_act;
        seg_next = SEG_ACTIVE_LOW ? ~seg_act : seg_act;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_reg <= '0;
            idx_reg     <= '0;
            snap_reg    <= '0;
            sel_reg     <= SEL_IDLE;
            seg_reg     <= SEG_IDLE;
        end else begin
            div_cnt_reg <= div_cnt_next;
            idx_reg     <= idx_next;
            snap_reg    <= snap_next;
            sel_reg     <= sel_next;
            seg_reg     <= seg_next;
        end
    end

    assign sel = sel_reg;
    assign seg = seg_reg;

endmodule

// File: tb/tb_stopwatch_seg_scan.sv
// Scoreboard bench for stopwatch_seg_scan with SCAN_DIV=8, BLANK_CYCLES=2.
// Expected (sel, seg) pairs are queued against slot step j; a monitor checks them.
module tb_stopwatch_seg_scan;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] ms = 8'h00;
    logic [7:0] sec = 8'h00;
    logic [7:0] mins = 8'h00;
    logic [5:0] sel;
    logic [7:0] seg;

    int cyc = 0;
    int base = 0;
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int         cyc;
        logic [5:0] sel;
        logic [7:0] seg;
        string      name;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    stopwatch_seg_scan #(
        .SCAN_DIV       (8),
        .BLANK_CYCLES   (2),
        .SEG_ACTIVE_LOW (1'b1),
        .SEL_ACTIVE_LOW (1'b1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .millsecond_10 (ms),
        .second        (sec),
        .minute        (mins),
        .sel           (sel),
        .seg           (seg)
    );

    task automatic compare(input string name, input logic [5:0] es, input logic [7:0] eg);
        n_vec++;
        if (sel !== es || seg !== eg) begin
            n_err++;
            $display("FAIL %s: sel=%h seg=%h, expected sel=%h seg=%h", name, sel, seg, es, eg);
        end else begin
            $display("ok   %s: sel=%h seg=%h", name, sel, seg);
        end
    endtask

    // Step j is sampled by the first posedge after base+j; its output shows one edge later.
    task automatic push(input string tag, input int j, input logic [5:0] s, input logic [7:0] g);
        exp_t e;
        e.cyc  = base + j + 1;
        e.sel  = s;
        e.seg  = g;
        e.name = $sformatf("%s_j%0d", tag, j);
        q.push_back(e);
    endtask

    task automatic go_to(input int j);
        while (cyc < base + j) @(negedge clk);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            if (e.cyc < cyc) begin
                n_vec++;
                n_err++;
                $display("FAIL %s: check slot missed at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
            end else begin
                compare(e.name, e.sel, e.seg);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        compare("reset_hold", 6'h3F, 8'hFF);

        // Frame 0 shows the zero snapshot; inputs change mid-frame.
        en = 1'b1; rst_n = 1'b1; base = cyc;
        push("s1", 0,   6'h3F, 8'hFF); push("s1", 1,   6'h3F, 8'hFF);
        push("s1", 2,   6'h3E, 8'hC0); push("s1", 18,  6'h3B, 8'h40);
        push("s1", 42,  6'h1F, 8'hFF); push("s1", 49,  6'h3F, 8'hFF);
        push("s1", 50,  6'h3E, 8'hF8); push("s1", 55,  6'h3E, 8'hF8);
        push("s1", 56,  6'h3F, 8'hFF); push("s1", 58,  6'h3D, 8'h99);
        push("s1", 66,  6'h3B, 8'h12); push("s1", 74,  6'h37, 8'hB0);
        push("s1", 82,  6'h2F, 8'h24); push("s1", 90,  6'h1F, 8'hFF);
        push("s1", 95,  6'h1F, 8'hFF); push("s1", 96,  6'h3F, 8'hFF);
        push("s1", 98,  6'h3E, 8'hF8); push("s1", 114, 6'h3B, 8'h02);
        push("s1", 146, 6'h3E, 8'hBF); push("s1", 162, 6'h3B, 8'h02);
        push("s1", 170, 6'h37, 8'hB0); push("s1", 171, 6'h3F, 8'hFF);
        push("s1", 174, 6'h3F, 8'hFF);
        go_to(10);  ms = 8'h47; sec = 8'h35; mins = 8'h02;
        go_to(58);  sec = 8'h36;
        go_to(100); ms = 8'h4A;
        go_to(171); en = 1'b0;
        go_to(172); ms = 8'h12; sec = 8'h59; mins = 8'h10;
        go_to(180);

        // Re-enable: snapshot holds the values seen while en was low.
        en = 1'b1; base = cyc;
        push("s2", 0,  6'h3F, 8'hFF); push("s2", 1,  6'h3F, 8'hFF);
        push("s2", 2,  6'h3E, 8'hA4); push("s2", 10, 6'h3D, 8'hF9);
        push("s2", 18, 6'h3B, 8'h10); push("s2", 26, 6'h37, 8'h92);
        push("s2", 34, 6'h2F, 8'h40); push("s2", 42, 6'h1F, 8'hF9);
        push("s2", 43, 6'h1F, 8'hF9);
        go_to(44);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 compare("async_rst", 6'h3F, 8'hFF);
        @(negedge clk);
        @(negedge clk);

        rst_n = 1'b1; base = cyc;
        push("s3", 0,  6'h3F, 8'hFF); push("s3", 2,  6'h3E, 8'hC0);
        push("s3", 18, 6'h3B, 8'h40); push("s3", 42, 6'h1F, 8'hFF);
        push("s3", 50, 6'h3E, 8'hA4);

        for (int k = 0; k < 300 && q.size() > 0; k++) @(negedge clk);
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL %s: never checked by cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
